// File: rtl/ser_pkg.sv
// Shared definitions for the serializer family: word-slot state encoding and
// a width helper usable in constant expressions.
package ser_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } ser_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ser_beat_mux.sv
// Combinational beat selector: picks one OUT_W slice of a wide word by beat
// counter, in either LSB-first or MSB-first order.
module ser_beat_mux
    import ser_pkg::*;
#(
    parameter  int OUT_W     = 16,
    parameter  int RATIO     = 4,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int IN_W      = OUT_W * RATIO,
    localparam int CNT_W     = clog2(RATIO)
) (
    input  logic [IN_W-1:0]  word,
    input  logic [CNT_W-1:0] cnt,
    output logic [OUT_W-1:0] beat
);

    logic [CNT_W-1:0] idx;

    always_comb begin
        idx  = MSB_FIRST ? (CNT_W'(RATIO - 1) - cnt) : cnt;
        beat = word[int'(idx) * OUT_W +: OUT_W];
    end

endmodule

// File: rtl/ser_param.sv
// Wide-to-narrow serializer with per-word beat count, selectable beat order,
// last-beat flag and a one-word look-ahead slot for bubble-free streaming.
module ser_param
    import ser_pkg::*;
#(
    parameter  int OUT_W     = 16,
    parameter  int RATIO     = 4,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int IN_W      = OUT_W * RATIO,
    localparam int CNT_W     = clog2(RATIO)
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             valid_in,
    input  logic [IN_W-1:0]  data_in,
    input  logic [CNT_W-1:0] len_in,
    output logic             stop_out,
    output logic             valid_out,
    output logic [OUT_W-1:0] data_out,
    output logic             last_out,
    input  logic             stop_in
);

    ser_state_t       state;
    logic [IN_W-1:0]  cur_word;
    logic [IN_W-1:0]  nxt_word;
    logic [CNT_W-1:0] cur_len;
    logic [CNT_W-1:0] nxt_len;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             xfer;
    logic             at_last;
    logic [IN_W-1:0]  src_word;
    logic [CNT_W-1:0] src_len;
    logic [CNT_W-1:0] src_cnt;
    logic             src_last;
    logic [OUT_W-1:0] beat;

    // Source of the beat that will be registered onto data_out if the output
    // advances this cycle: next beat of CUR, first beat of NXT, or first beat
    // of the incoming word.
    always_comb begin
        accept   = valid_in && !stop_out;
        xfer     = valid_out && !stop_in;
        at_last  = (cnt == cur_len);
        src_word = cur_word;
        src_len  = cur_len;
        src_cnt  = cnt + 1'b1;
        if (state == ST_FULL && at_last) begin
            src_word = nxt_word;
            src_len  = nxt_len;
            src_cnt  = '0;
        end else if (state == ST_EMPTY || at_last) begin
            src_word = data_in;
            src_len  = len_in;
            src_cnt  = '0;
        end
        src_last = (src_cnt == src_len);
    end

    ser_beat_mux #(
        .OUT_W    (OUT_W),
        .RATIO    (RATIO),
        .MSB_FIRST(MSB_FIRST)
    ) u_mux (
        .word(src_word),
        .cnt (src_cnt),
        .beat(beat)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= ST_EMPTY;
            cur_word  <= '0;
            nxt_word  <= '0;
            cur_len   <= '0;
            nxt_len   <= '0;
            cnt       <= '0;
            stop_out  <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        cur_word  <= data_in;
                        cur_len   <= len_in;
                        cnt       <= '0;
                        data_out  <= beat;
                        last_out  <= src_last;
                        valid_out <= 1'b1;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (xfer && at_last) begin
                        if (accept) begin
                            cur_word <= data_in;
                            cur_len  <= len_in;
                            cnt      <= '0;
                            data_out <= beat;
                            last_out <= src_last;
                        end else begin
                            valid_out <= 1'b0;
                            last_out  <= 1'b0;
                            state     <= ST_EMPTY;
                        end
                    end else begin
                        if (xfer) begin
                            cnt      <= src_cnt;
                            data_out <= beat;
                            last_out <= src_last;
                        end
                        if (accept) begin
                            nxt_word <= data_in;
                            nxt_len  <= len_in;
                            stop_out <= 1'b1;
                            state    <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        cnt      <= src_cnt;
                        data_out <= beat;
                        last_out <= src_last;
                        if (at_last) begin
                            cur_word <= nxt_word;
                            cur_len  <= nxt_len;
                            stop_out <= 1'b0;
                            state    <= ST_BUSY;
                        end
                    end
                end
                default: begin
                    valid_out <= 1'b0;
                    last_out  <= 1'b0;
                    stop_out  <= 1'b0;
                    state     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_param.sv
// Directed bench for ser_param: LSB-first and MSB-first instances share one
// stimulus stream; expected beats are written out by hand.
module tb_ser_param;

    logic        clk;
    logic        res_n;
    logic        valid_in;
    logic [63:0] data_in;
    logic [1:0]  len_in;
    logic        stop_in;

    logic        stop_out,  valid_out,  last_out;
    logic [15:0] data_out;
    logic        stop_out_m, valid_out_m, last_out_m;
    logic [15:0] data_out_m;

    int n_checks;
    int n_pass;

    ser_param #(.OUT_W(16), .RATIO(4), .MSB_FIRST(1'b0)) dut (
        .clk      (clk),
        .res_n    (res_n),
        .valid_in (valid_in),
        .data_in  (data_in),
        .len_in   (len_in),
        .stop_out (stop_out),
        .valid_out(valid_out),
        .data_out (data_out),
        .last_out (last_out),
        .stop_in  (stop_in)
    );

    ser_param #(.OUT_W(16), .RATIO(4), .MSB_FIRST(1'b1)) dut_m (
        .clk      (clk),
        .res_n    (res_n),
        .valid_in (valid_in),
        .data_in  (data_in),
        .len_in   (len_in),
        .stop_out (stop_out_m),
        .valid_out(valid_out_m),
        .data_out (data_out_m),
        .last_out (last_out_m),
        .stop_in  (stop_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [15:0] d,
                              input logic l, input logic s);
        check({tag, ".valid"}, 64'(valid_out), 64'(v));
        if (v) check({tag, ".data"}, 64'(data_out), 64'(d));
        check({tag, ".last"}, 64'(last_out), 64'(l));
        check({tag, ".stop"}, 64'(stop_out), 64'(s));
    endtask

    localparam logic [63:0] W_STD = 64'h4444_3333_2222_1111;
    localparam logic [63:0] W_A   = 64'hA004_A003_A002_A001;
    localparam logic [63:0] W_B   = 64'hB004_B003_B002_B001;
    localparam logic [63:0] W_C   = 64'hC004_C003_C002_C001;
    localparam logic [63:0] W_D   = 64'hD004_D003_D002_D001;

    logic [15:0] lsb_beats [4];
    logic [15:0] msb_beats [4];
    logic [15:0] ab_beats  [8];
    logic        ab_stop   [8];
    logic [15:0] stall_beats [7];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        lsb_beats   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        msb_beats   = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
        ab_beats    = '{16'hA001, 16'hA002, 16'hA003, 16'hA004,
                        16'hB001, 16'hB002, 16'hB003, 16'hB004};
        ab_stop     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        stall_beats = '{16'h1111, 16'h2222, 16'h2222, 16'h2222, 16'h2222,
                        16'h3333, 16'h4444};

        res_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        len_in   = '0;
        stop_in  = 1'b0;
        #23;
        check("rst.valid", 64'(valid_out), 64'd0);
        check("rst.stop",  64'(stop_out),  64'd0);
        check("rst.last",  64'(last_out),  64'd0);
        check("rst.data",  64'(data_out),  64'd0);
        check("rst.data_m", 64'(data_out_m), 64'd0);
        res_n = 1'b1;
        tick();

        // Single full word, both beat orders
        valid_in = 1'b1; data_in = W_STD; len_in = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            valid_in = 1'b0;
            expect_out($sformatf("single%0d", i), 1'b1, lsb_beats[i], i == 3, 1'b0);
            check($sformatf("msb%0d.data", i), 64'(data_out_m), 64'(msb_beats[i]));
            check($sformatf("msb%0d.last", i), 64'(last_out_m), 64'(i == 3));
        end
        tick();
        expect_out("single_idle", 1'b0, 16'h0, 1'b0, 1'b0);
        check("msb_idle.valid", 64'(valid_out_m), 64'd0);

        // Back-to-back words through the look-ahead slot
        valid_in = 1'b1; data_in = W_A; len_in = 2'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) data_in = W_B;
            if (i == 1) valid_in = 1'b0;
            expect_out($sformatf("b2b%0d", i), 1'b1, ab_beats[i], (i == 3) || (i == 7), ab_stop[i]);
        end
        tick();
        expect_out("b2b_idle", 1'b0, 16'h0, 1'b0, 1'b0);

        // Sink stall for three cycles on beat 2222
        valid_in = 1'b1; data_in = W_STD; len_in = 2'd3;
        for (int i = 0; i < 7; i++) begin
            tick();
            valid_in = 1'b0;
            expect_out($sformatf("stall%0d", i), 1'b1, stall_beats[i], i == 6, 1'b0);
            stop_in = (i >= 1) && (i <= 3);
        end
        tick();
        expect_out("stall_idle", 1'b0, 16'h0, 1'b0, 1'b0);

        // Short words: len 0 then len 1, second accepted on the first's last beat
        valid_in = 1'b1; data_in = W_C; len_in = 2'd0;
        tick();
        data_in = W_D; len_in = 2'd1;
        expect_out("len0", 1'b1, 16'hC001, 1'b1, 1'b0);
        tick();
        valid_in = 1'b0;
        expect_out("len1_b0", 1'b1, 16'hD001, 1'b0, 1'b0);
        tick();
        expect_out("len1_b1", 1'b1, 16'hD002, 1'b1, 1'b0);
        tick();
        expect_out("len_idle", 1'b0, 16'h0, 1'b0, 1'b0);

        // Asynchronous reset with both slots occupied
        valid_in = 1'b1; data_in = W_A; len_in = 2'd3;
        tick();
        data_in = W_B;
        tick();
        valid_in = 1'b0;
        expect_out("pre_rst", 1'b1, 16'hA002, 1'b0, 1'b1);
        #2;
        res_n = 1'b0;
        #1;
        check("arst.valid", 64'(valid_out), 64'd0);
        check("arst.stop",  64'(stop_out),  64'd0);
        check("arst.last",  64'(last_out),  64'd0);
        check("arst.data",  64'(data_out),  64'd0);
        #4;
        res_n = 1'b1;
        tick();
        tick();
        expect_out("post_rst_idle", 1'b0, 16'h0, 1'b0, 1'b0);
        valid_in = 1'b1; data_in = W_STD; len_in = 2'd3;
        tick();
        valid_in = 1'b0;
        expect_out("post_rst_b0", 1'b1, 16'h1111, 1'b0, 1'b0);
        tick();
        expect_out("post_rst_b1", 1'b1, 16'h2222, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
